// File: rtl/prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_ctrl
// Purpose  : Boot loader that takes a framed byte stream (length, data,
//            checksum), writes it into program memory, zero-fills the rest
//            and releases the CPU only after a verified load.
// Revision : 1.0  initial release
// ============================================================================
module prog_loader_ctrl #(
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] FILL_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ewr,
    output logic [ADDR_W-1:0] ead,
    output logic [DATA_W-1:0] edat,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [DATA_W-1:0] c_depth    = DATA_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
    localparam logic [1:0]        c_err_len  = 2'b01;
    localparam logic [1:0]        c_err_csum = 2'b10;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_sum;
    logic              r_dwr;
    logic [ADDR_W-1:0] r_dad;
    logic [DATA_W-1:0] r_ddat;
    logic              r_done;
    logic [1:0]        r_err_code;
    logic [1:0]        w_err_val;
    logic              w_accept;
    logic              w_len_ok;

    assign in_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept = in_valid && in_ready;
    assign w_len_ok = (in_data != '0) && (in_data <= c_depth);

    always_comb begin
        w_next    = r_state;
        w_err_val = 2'b00;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_accept) begin
                    w_next    = w_len_ok ? S_DATA : S_ERR;
                    w_err_val = c_err_len;
                end
            end
            S_DATA: begin
                if (w_accept && (r_cnt == c_cnt_one)) w_next = S_CSUM;
            end
            S_CSUM: begin
                // The address wraps to 0 only after a full-depth frame, so no fill is needed
                if (w_accept) begin
                    if (in_data == r_sum) w_next = (r_addr == '0) ? S_RUN : S_FILL;
                    else                  w_next = S_ERR;
                    w_err_val = c_err_csum;
                end
            end
            S_FILL: begin
                if (r_addr == c_last) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_sum      <= '0;
            r_dwr      <= 1'b0;
            r_dad      <= '0;
            r_ddat     <= '0;
            r_done     <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state <= w_next;
            r_dwr   <= 1'b0;
            r_done  <= (w_next == S_RUN) && (r_state != S_RUN);

            if ((w_next == S_ERR) && (r_state != S_ERR)) r_err_code <= w_err_val;
            else if (w_next == S_LEN)                    r_err_code <= 2'b00;

            if ((r_state == S_LEN) && w_accept) begin
                r_cnt  <= in_data[ADDR_W:0];
                r_addr <= '0;
                r_sum  <= '0;
            end

            if ((r_state == S_DATA) && w_accept) begin
                r_dwr  <= 1'b1;
                r_dad  <= r_addr;
                r_ddat <= in_data;
                r_addr <= r_addr + c_addr_one;
                r_sum  <= r_sum + in_data;
                r_cnt  <= r_cnt - c_cnt_one;
            end

            if ((r_state == S_FILL) && (w_next == S_FILL)) r_addr <= r_addr + c_addr_one;
        end
    end

    // Fill writes come straight from the state; data writes trail their accept by a cycle
    assign ewr      = r_dwr || (r_state == S_FILL);
    assign ead      = (r_state == S_FILL) ? r_addr : r_dad;
    assign edat     = (r_state == S_FILL) ? FILL_BYTE : r_ddat;
    assign cpu_run  = (r_state == S_RUN);
    assign busy     = (r_state == S_LEN) || (r_state == S_DATA) ||
                      (r_state == S_CSUM) || (r_state == S_FILL);
    assign done     = r_done;
    assign err      = (r_state == S_ERR);
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader_ctrl
// Purpose  : Frame-level reference model and per-cycle write checker for the
//            program loader; directed frames followed by random frames.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, ewr, cpu_run, busy, done, err;
    logic [4:0] ead;
    logic [7:0] edat;
    logic [1:0] err_code;

    prog_loader_ctrl #(.ADDR_W(5), .DEPTH(32), .DATA_W(8), .FILL_BYTE(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ewr(ewr), .ead(ead), .edat(edat), .cpu_run(cpu_run),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [12:0] exp_q[$];
    logic [7:0]  dut_mem[32];
    logic [7:0]  ref_mem[32];
    logic [7:0]  fb[32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every write must be the next one the frame model predicted
    always @(negedge clk) begin
        if (rst) begin
            if (ewr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {19'd0, ead, edat}, 32'hFFFF);
                end else begin
                    logic [12:0] w;
                    w = exp_q.pop_front();
                    chk("ead", ead, w[12:8]);
                    chk("edat", edat, w[7:0]);
                end
                dut_mem[ead] = edat;
                wr_cnt++;
            end
            if (done) done_cnt++;
            chk("run_and_busy", cpu_run & busy, 0);
        end
    end

    function automatic logic [7:0] sumf(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s += fb[i];
        return s;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit v, rdy;
        int t = 0;
        forever begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = b;
            rdy      = in_ready;
            @(posedge clk); #1;
            if (v && rdy) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finalize(input bit ok, input logic [1:0] code);
        int t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("settle_timeout", busy, 0);
        @(negedge clk); #1;
        chk("cpu_run", cpu_run, ok);
        chk("err", err, !ok);
        chk("err_code", err_code, code);
        chk("done_count", done_cnt, ok ? 1 : 0);
        chk("writes_left", exp_q.size(), 0);
        chk("in_ready_idle", in_ready, 0);
        for (int i = 0; i < 32; i++) chk("mem_image", dut_mem[i], ref_mem[i]);
    endtask

    task automatic reset_mid_frame();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_ewr", ewr, 0);
        chk("rst_outputs", {in_ready, busy, cpu_run, done, err, err_code, ead, edat}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 0);
        chk("post_rst_run", cpu_run, 0);
    endtask

    task automatic run_frame(input logic [7:0] len, input logic [7:0] csum, input bit gaps,
                             input int abort_at, input bit poke);
        int n;
        bit good;
        pulse_start();
        done_cnt = 0;
        wr_cnt   = 0;
        n = int'(len);
        send_byte(len, gaps);
        if (n < 1 || n > 32) begin
            finalize(1'b0, 2'b01);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                reset_mid_frame();
                return;
            end
            exp_q.push_back({5'(i), fb[i]});
            ref_mem[i] = fb[i];
            send_byte(fb[i], gaps);
            if (poke && i == 1) pulse_start();
        end
        good = (csum == sumf(n));
        send_byte(csum, gaps);
        if (good) begin
            for (int a = n; a < 32; a++) begin
                exp_q.push_back({5'(a), 8'h00});
                ref_mem[a] = 8'h00;
            end
        end
        finalize(good, good ? 2'b00 : 2'b10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            dut_mem[i] = 8'hA5;
            ref_mem[i] = 8'hA5;
        end
        #3;
        chk("reset_outputs", {in_ready, ewr, ead, edat, cpu_run, busy, done, err, err_code}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 0);

        // N=3, continuous valid
        fb[0] = 8'h20; fb[1] = 8'h41; fb[2] = 8'h05;
        run_frame(8'd3, 8'h66, 1'b0, -1, 1'b0);
        chk("lit_mem0", dut_mem[0], 8'h20);
        chk("lit_mem2", dut_mem[2], 8'h05);
        chk("lit_mem3", dut_mem[3], 8'h00);
        chk("lit_wr_cnt_n3", wr_cnt, 32);

        // N=32, no fill
        for (int i = 0; i < 32; i++) fb[i] = 8'(i);
        run_frame(8'd32, 8'hF0, 1'b0, -1, 1'b0);
        chk("lit_mem31", dut_mem[31], 8'h1F);
        chk("lit_wr_cnt_n32", wr_cnt, 32);

        // Bad checksum then recovery
        fb[0] = 8'h10; fb[1] = 8'h20;
        run_frame(8'd2, 8'h31, 1'b0, -1, 1'b0);
        chk("lit_code_csum", err_code, 2'b10);
        chk("lit_wr_cnt_bad", wr_cnt, 2);
        fb[0] = 8'h20; fb[1] = 8'h41; fb[2] = 8'h05;
        run_frame(8'd3, 8'h66, 1'b0, -1, 1'b0);

        // Bad lengths
        run_frame(8'h00, 8'h00, 1'b0, -1, 1'b0);
        chk("lit_code_len0", err_code, 2'b01);
        chk("lit_wr_cnt_len0", wr_cnt, 0);
        run_frame(8'h21, 8'h00, 1'b0, -1, 1'b0);
        chk("lit_code_len33", err_code, 2'b01);

        // Gapped valid with a start pulse mid-frame
        fb[0] = 8'hA1; fb[1] = 8'hB2; fb[2] = 8'hC3; fb[3] = 8'hD4;
        run_frame(8'd4, 8'hEA, 1'b1, -1, 1'b1);
        chk("lit_mem3_gap", dut_mem[3], 8'hD4);

        // Reset after 2 of 5 bytes, then a full load
        for (int i = 0; i < 5; i++) fb[i] = 8'($urandom);
        run_frame(8'd5, 8'h00, 1'b0, 2, 1'b0);
        for (int i = 0; i < 32; i++) chk("partial_image", dut_mem[i], ref_mem[i]);
        run_frame(8'd5, sumf(5), 1'b0, -1, 1'b0);

        // Random frames
        for (int k = 0; k < 25; k++) begin
            logic [7:0] len, cs;
            if ($urandom_range(0, 9) == 0)
                len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255));
            else
                len = 8'($urandom_range(1, 32));
            for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
            cs = sumf((len <= 8'd32) ? int'(len) : 0);
            if ($urandom_range(0, 4) == 0) cs = cs + 8'($urandom_range(1, 255));
            run_frame(len, cs, 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
